// File: rtl/dump_ctrl.sv
// dump_ctrl: streams one channel's capture RAM queue to the UART
// transmitter. Reading starts at the oldest sample and goes in capture order.
// One byte is sent per entry. Each next read waits for the transmitter's
// tx_done handshake. When the last byte has gone out, capture_done is cleared
// so that the capture controller can re-arm.
module dump_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump_start,
    input  logic [2:0]      dump_chan,
    input  logic            capture_done,
    input  logic [LOG2-1:0] waddr,
    input  logic [7:0]      ram_rdata,
    input  logic            tx_done,
    output logic [2:0]      chan_sel,
    output logic            ren,
    output logic [LOG2-1:0] raddr,
    output logic [7:0]      tx_data,
    output logic            trmt,
    output logic            dump_busy,
    output logic            dump_done,
    output logic            dump_err,
    output logic            clr_capture_done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WAIT_TX,
        DONE
    } state_t;

    // Highest legal RAM address. The read pointer wraps from here back to 0.
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [2:0]      MAX_CHAN = 3'd4;

    state_t          state;
    logic [LOG2-1:0] cnt;
    logic            req_ok;

    // A request is accepted only for an existing channel with a finished capture.
    assign req_ok = (dump_chan <= MAX_CHAN) && capture_done;

    // Dump sequencer: state, read pointer, byte counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            chan_sel         <= '0;
            raddr            <= '0;
            tx_data          <= '0;
            ren              <= 1'b0;
            trmt             <= 1'b0;
            dump_busy        <= 1'b0;
            dump_done        <= 1'b0;
            dump_err         <= 1'b0;
            clr_capture_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
            // NOTE: single-cycle strobes default low here and are raised only on the cycle they apply.
            ren              <= 1'b0;
            trmt             <= 1'b0;
            dump_done        <= 1'b0;
            dump_err         <= 1'b0;
            clr_capture_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (dump_start) begin
                        if (req_ok) begin
                            chan_sel  <= dump_chan;
                            raddr     <= waddr;
                            cnt       <= '0;
                            ren       <= 1'b1;
                            dump_busy <= 1'b1;
                            state     <= READ;
                        end else begin
                            dump_err  <= 1'b1;
                        end
                    end
                end

                // ren is high for this one cycle. The RAM returns data during LATCH.
                READ: begin
                    state <= LATCH;
                end

                // Capture the RAM byte, then start the transmitter on the next cycle together with it.
                LATCH: begin
                    tx_data <= ram_rdata;
                    trmt    <= 1'b1;
                    state   <= WAIT_TX;
                end

                // raddr and tx_data stay put until the transmitter reports the byte has gone out.
                WAIT_TX: begin
                    if (tx_done) begin
                        if (cnt == LAST) begin
                            dump_done        <= 1'b1;
                            clr_capture_done <= 1'b1;
                            state            <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            raddr <= (raddr == LAST) ? '0 : raddr + 1'b1;
                            ren   <= 1'b1;
                            state <= READ;
                        end
                    end
                end

                // dump_done / clr_capture_done are high during this cycle.
                DONE: begin
                    dump_busy <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    dump_busy <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dump_ctrl.md
Name: dump_ctrl

Overview:
- Sequences readout of captured samples from the per-channel RAM queues to the host UART transmitter once a capture has completed.
- Reads all ENTRIES locations of one selected channel in chronological order, oldest sample first, starting at the capture write pointer and wrapping at ENTRIES-1.
- Sends one byte per entry and waits on the transmitter handshake before each next read.
- Clears capture_done on completion so the capture controller can re-arm.

Parameters:
ENTRIES, 384, number of entries per RAM queue (12288 on DE0 build)
LOG2, 9, width of RAM addresses; must satisfy 2^LOG2 >= ENTRIES

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
dump_start  input  1  single-cycle pulse from command decoder requesting a dump
dump_chan  input  3  channel to dump, valid 0..4
capture_done  input  1  capture-complete flag held by command/config logic
waddr  input  LOG2  capture write pointer at end of capture; equals the oldest sample location
ram_rdata  input  8  read data from the RAM queue selected by chan_sel, valid 1 cycle after ren
tx_done  input  1  single-cycle pulse from UART transmitter when a byte has finished
chan_sel  output  3  latched channel select driving the external RAM read-data mux
ren  output  1  RAM read enable
raddr  output  LOG2  RAM read address
tx_data  output  8  byte to transmit
trmt  output  1  single-cycle pulse starting transmission of tx_data
dump_busy  output  1  high from accepted dump_start until return to IDLE
dump_done  output  1  single-cycle pulse when the last byte's tx_done is received
dump_err  output  1  single-cycle pulse when a dump request is rejected
clr_capture_done  output  1  single-cycle pulse, coincident with dump_done

Behaviour:
- Reset: state IDLE. All outputs are 0, including raddr, chan_sel, tx_data and the internal byte counter cnt (LOG2 bits).
- State register and datapath registers reset asynchronously. Reset mid-dump aborts immediately; no further trmt, no dump_done, capture_done is not cleared.
- States: IDLE, READ, LATCH, WAIT_TX, DONE.
- IDLE:
  - On dump_start with dump_chan <= 4 and capture_done = 1: latch chan_sel <= dump_chan, raddr <= waddr, cnt <= 0; go to READ.
  - On dump_start with dump_chan > 4 or capture_done = 0: pulse dump_err next cycle, stay IDLE, no RAM access.
- READ: ren = 1 for exactly one cycle at the current raddr; go to LATCH.
- LATCH: tx_data <= ram_rdata (registered); trmt = 1 for exactly one cycle; go to WAIT_TX.
- WAIT_TX: hold tx_data and raddr stable until tx_done.
  - If tx_done and cnt == ENTRIES-1, go to DONE.
  - Otherwise on tx_done: cnt <= cnt+1; raddr <= 0 when raddr == ENTRIES-1, else raddr+1; go to READ.
- DONE: dump_done = 1 and clr_capture_done = 1 for one cycle; go to IDLE.
- dump_busy = (state != IDLE), registered so it rises the cycle after the accepted dump_start.
- dump_start while busy is ignored; no error pulse.
- tx_done outside WAIT_TX is ignored.
- raddr never exceeds ENTRIES-1. waddr values >= ENTRIES are illegal; behaviour on them is undefined.
- Exactly ENTRIES trmt pulses per accepted dump.
- Byte k (k = 0..ENTRIES-1) is read from address (waddr + k) mod ENTRIES.
- Minimum per-byte spacing is 3 cycles (READ, LATCH, WAIT_TX with an immediate tx_done).
- Channel does not change during a dump; chan_sel is latched only at acceptance.

Test Plan:
- capture_done=1, waddr=0, dump_chan=2, tx_done returned 10 cycles after each trmt:
  - Required: ren addresses 0,1,...,383; 384 trmt pulses; tx_data equals RAM model contents in order; chan_sel=2 throughout.
  - Required: dump_done and clr_capture_done pulse once, together, after the 384th tx_done.
- waddr=380, ENTRIES=384: required read order 380,381,382,383,0,1,...,379; count is exactly 384; no address >= 384.
- dump_start with dump_chan=5, capture_done=1: required dump_err pulse; no ren, no trmt; dump_busy stays 0.
- dump_start with capture_done=0: required dump_err pulse and state stays IDLE. A second dump_start issued while a valid dump is busy: required no effect and no dump_err.
- tx_done held off for 1000 cycles mid-dump: required trmt not re-pulsed; raddr and tx_data stable. Spurious tx_done in IDLE: required no activity.
- rst_n asserted after the 100th byte: required all outputs 0 asynchronously. After release with a new dump_start (waddr=5): the dump restarts at address 5 with cnt=0.
